// File: rtl/membrane_update_unit_if.sv
// Handshake and data bundle between the IPSC stage, its controller
// and membrane_update_unit.
interface membrane_update_unit_if #(
    parameter int IW = 32,
    parameter int F  = 32,
    parameter int RW = 8
);
    localparam int DW = IW + F;

    logic                 i_start;
    logic                 i_no_input;
    logic signed [DW-1:0] i_vmem;
    logic [RW-1:0]        i_refcnt;
    logic signed [DW-1:0] i_ipsc;
    logic                 i_ipsc_valid;
    logic                 i_ipsc_last;
    logic signed [IW-1:0] i_vrest;
    logic signed [IW-1:0] i_vth;
    logic signed [IW-1:0] i_vreset;
    logic signed [DW-1:0] i_leak_factor;
    logic [RW-1:0]        i_ref_period;
    logic                 o_busy;
    logic                 o_done;
    logic signed [DW-1:0] o_vmem;
    logic [RW-1:0]        o_refcnt;
    logic                 o_spike;

    modport master (
        output i_start, i_no_input, i_vmem, i_refcnt,
        output i_ipsc, i_ipsc_valid, i_ipsc_last,
        output i_vrest, i_vth, i_vreset, i_leak_factor, i_ref_period,
        input  o_busy, o_done, o_vmem, o_refcnt, o_spike
    );

    modport slave (
        input  i_start, i_no_input, i_vmem, i_refcnt,
        input  i_ipsc, i_ipsc_valid, i_ipsc_last,
        input  i_vrest, i_vth, i_vreset, i_leak_factor, i_ref_period,
        output o_busy, o_done, o_vmem, o_refcnt, o_spike
    );
endinterface

// File: rtl/membrane_update_unit.sv
// Per-neuron membrane update: IPSC accumulation, leak towards Vrest,
// refractory handling and threshold test in Q(I.F) fixed point.
module membrane_update_unit #(
    parameter int INTEGER_WIDTH    = 32,
    parameter int DATA_WIDTH_FRAC  = 32,
    parameter int DATA_WIDTH       = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int REFRACTORY_WIDTH = 8
) (
    input logic                   i_clk,
    input logic                   i_rst,
    membrane_update_unit_if.slave if_mu
);
    localparam int F  = DATA_WIDTH_FRAC;
    localparam int DW = DATA_WIDTH;
    localparam int RW = REFRACTORY_WIDTH;
    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_LEAK,
        S_FIRE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DW-1:0] r_vmem;
    logic signed [DW-1:0] r_acc;
    logic signed [DW-1:0] r_vnew;
    logic signed [DW-1:0] r_vmem_out;
    logic [RW-1:0]        r_refcnt;
    logic [RW-1:0]        r_refcnt_out;
    logic                 r_done;
    logic                 r_spike;

    logic [DW:0]            w_acc_sum;
    logic signed [DW-1:0]   w_acc_sat;
    logic signed [DW-1:0]   w_vrest_ext;
    logic signed [DW-1:0]   w_vth_ext;
    logic signed [DW-1:0]   w_vreset_ext;
    logic signed [DW-1:0]   w_diff;
    logic signed [DW+F-1:0] w_prod;
    logic signed [DW-1:0]   w_mulq;
    logic [DW+1:0]          w_sum;
    logic signed [DW-1:0]   w_vnew;

    assign w_vrest_ext  = {if_mu.i_vrest[INTEGER_WIDTH-1:0], {F{1'b0}}};
    assign w_vth_ext    = {if_mu.i_vth[INTEGER_WIDTH-1:0], {F{1'b0}}};
    assign w_vreset_ext = {if_mu.i_vreset[INTEGER_WIDTH-1:0], {F{1'b0}}};

    assign w_acc_sum = {r_acc[DW-1], r_acc}
                     + {if_mu.i_ipsc[DW-1], if_mu.i_ipsc};
    assign w_acc_sat = (w_acc_sum[DW] == w_acc_sum[DW-1]) ? w_acc_sum[DW-1:0]
                     : (w_acc_sum[DW] ? SAT_MIN : SAT_MAX);

    // Only product bits [DW+F-1:F] are kept, so the multiplier is DW+F wide.
    assign w_diff = w_vrest_ext - r_vmem;
    assign w_prod = {{F{w_diff[DW-1]}}, w_diff}
                  * {{F{if_mu.i_leak_factor[DW-1]}}, if_mu.i_leak_factor};
    assign w_mulq = DW'(w_prod >>> F);

    assign w_sum = {{2{r_vmem[DW-1]}}, r_vmem}
                 + {{2{w_mulq[DW-1]}}, w_mulq}
                 + {{2{r_acc[DW-1]}}, r_acc};
    assign w_vnew = (w_sum[DW+1:DW-1] == 3'b000 || w_sum[DW+1:DW-1] == 3'b111)
                  ? w_sum[DW-1:0]
                  : (w_sum[DW+1] ? SAT_MIN : SAT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (if_mu.i_start) w_next = if_mu.i_no_input ? S_LEAK : S_ACCUM;
            S_ACCUM: if (if_mu.i_ipsc_valid && if_mu.i_ipsc_last) w_next = S_LEAK;
            S_LEAK:  w_next = S_FIRE;
            S_FIRE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vmem       <= '0;
            r_acc        <= '0;
            r_vnew       <= '0;
            r_refcnt     <= '0;
            r_vmem_out   <= '0;
            r_refcnt_out <= '0;
            r_spike      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_mu.i_start) begin
                        r_vmem   <= if_mu.i_vmem;
                        r_refcnt <= if_mu.i_refcnt;
                        r_acc    <= '0;
                    end
                end
                S_ACCUM: begin
                    if (if_mu.i_ipsc_valid) r_acc <= w_acc_sat;
                end
                S_LEAK: begin
                    r_vnew <= w_vnew;
                end
                S_FIRE: begin
                    r_done <= 1'b1;
                    // A refractory neuron is clamped regardless of its input.
                    if (r_refcnt != '0) begin
                        r_vmem_out   <= w_vreset_ext;
                        r_refcnt_out <= r_refcnt - RW'(1);
                        r_spike      <= 1'b0;
                    end else if (r_vnew >= w_vth_ext) begin
                        r_vmem_out   <= w_vreset_ext;
                        r_refcnt_out <= if_mu.i_ref_period;
                        r_spike      <= 1'b1;
                    end else begin
                        r_vmem_out   <= r_vnew;
                        r_refcnt_out <= '0;
                        r_spike      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_mu.o_busy   = (r_state != S_IDLE);
    assign if_mu.o_done   = r_done;
    assign if_mu.o_vmem   = r_vmem_out;
    assign if_mu.o_refcnt = r_refcnt_out;
    assign if_mu.o_spike  = r_spike;
endmodule

// File: tb/tb_membrane_update_unit.sv
// Scoreboard bench for membrane_update_unit: directed corner cases
// plus randomized neurons against an arithmetic reference model.
module tb_membrane_update_unit;
    typedef logic signed [63:0]  q_t;
    typedef logic signed [127:0] w_t;
    typedef struct {
        q_t          vmem;
        logic [7:0]  rc;
        logic        spk;
        int          cyc;
        string       nm;
    } exp_t;

    localparam w_t HI = (128'sd1 <<< 63) - 128'sd1;
    localparam w_t LO = -(128'sd1 <<< 63);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t me;

    membrane_update_unit_if #(.IW(32), .F(32), .RW(8)) bus ();

    membrane_update_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .if_mu (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic q_t qf(input real r);
        return q_t'(longint'(r * 4294967296.0));
    endfunction

    function automatic q_t qi(input logic signed [31:0] i);
        return {i, 32'h0};
    endfunction

    function automatic q_t sat(input w_t v);
        if (v > HI) return q_t'(HI);
        if (v < LO) return q_t'(LO);
        return v[63:0];
    endfunction

    // Reference: arithmetic straight from the update rules.
    task automatic model(input q_t vmem, input logic [7:0] rc, input q_t terms[$],
                         input logic signed [31:0] vrest, input logic signed [31:0] vth,
                         input logic signed [31:0] vreset, input q_t lf,
                         input logic [7:0] rp, output q_t ev, output logic [7:0] er,
                         output logic es);
        w_t acc, t, vm, vr, l, prod, vnew, th;
        q_t mq;
        acc = 0;
        foreach (terms[i]) begin
            t = terms[i];
            acc = sat(acc + t);
        end
        vm = vmem;
        vr = vrest;
        vr = vr * (128'sd1 <<< 32);
        l = lf;
        prod = (vr - vm) * l;
        mq = q_t'(prod >>> 32);
        t = mq;
        vnew = sat(vm + t + acc);
        th = vth;
        th = th * (128'sd1 <<< 32);
        if (rc != 0) begin
            ev = qi(vreset); er = rc - 8'd1; es = 1'b0;
        end else if (vnew >= th) begin
            ev = qi(vreset); er = rp; es = 1'b1;
        end else begin
            ev = vnew[63:0]; er = 8'd0; es = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.o_done) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                me = sb.pop_front();
                if (bus.o_vmem !== me.vmem || bus.o_refcnt !== me.rc ||
                    bus.o_spike !== me.spk || cyc != me.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got vmem=%h rc=%0d spk=%b cyc=%0d expected vmem=%h rc=%0d spk=%b cyc=%0d",
                             me.nm, bus.o_vmem, bus.o_refcnt, bus.o_spike, cyc,
                             me.vmem, me.rc, me.spk, me.cyc);
                end
            end
        end
    end

    task automatic run_neuron(input string nm, input q_t vmem, input logic [7:0] rc,
                              input q_t terms[$], input logic signed [31:0] vrest,
                              input logic signed [31:0] vth, input logic signed [31:0] vreset,
                              input q_t lf, input logic [7:0] rp, input int gap_at,
                              input bit rnd_gap, input bit poke, input q_t ev,
                              input logic [7:0] er, input logic es);
        int   t;
        exp_t e;
        @(negedge clk);
        bus.i_vrest = vrest; bus.i_vth = vth; bus.i_vreset = vreset;
        bus.i_leak_factor = lf; bus.i_ref_period = rp;
        bus.i_start = 1'b1; bus.i_no_input = (terms.size() == 0);
        bus.i_vmem = vmem; bus.i_refcnt = rc;
        bus.i_ipsc_valid = 1'b0; bus.i_ipsc_last = 1'b0;
        @(posedge clk); #1; t = cyc;
        @(negedge clk);
        bus.i_start = poke; bus.i_no_input = poke;
        bus.i_vmem = poke ? qi(99) : vmem;
        bus.i_refcnt = poke ? 8'd7 : rc;
        for (int i = 0; i < terms.size(); i++) begin
            if (i == gap_at || (rnd_gap && $urandom_range(0, 2) == 0)) begin
                bus.i_ipsc_valid = 1'b0;
                bus.i_ipsc_last = 1'($urandom_range(0, 1));
                bus.i_ipsc = qi(1000);
                @(posedge clk); @(negedge clk);
            end
            bus.i_ipsc_valid = 1'b1;
            bus.i_ipsc = terms[i];
            bus.i_ipsc_last = (i == terms.size() - 1);
            @(posedge clk); #1; t = cyc;
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        bus.i_start = poke; bus.i_no_input = poke;
        bus.i_ipsc_valid = poke; bus.i_ipsc_last = poke; bus.i_ipsc = qi(1000);
        e.vmem = ev; e.rc = er; e.spk = es; e.cyc = t + 2; e.nm = nm;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        bus.i_start = 1'b0; bus.i_ipsc_valid = 1'b0; bus.i_ipsc_last = 1'b0;
    endtask

    task automatic idle_junk(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_ipsc_valid = 1'b1; bus.i_ipsc_last = 1'b1; bus.i_ipsc = qi(500);
        end
        @(negedge clk);
        bus.i_ipsc_valid = 1'b0; bus.i_ipsc_last = 1'b0;
    endtask

    initial begin
        q_t          tq[$];
        q_t          ev;
        logic [7:0]  er;
        logic        es;
        q_t          vm, lf;
        logic [7:0]  rc, rp;
        logic signed [31:0] vrest, vth, vreset;
        int          n;

        bus.i_start = 0; bus.i_no_input = 0; bus.i_vmem = 0; bus.i_refcnt = 0;
        bus.i_ipsc = 0; bus.i_ipsc_valid = 0; bus.i_ipsc_last = 0;
        bus.i_vrest = 0; bus.i_vth = 0; bus.i_vreset = 0;
        bus.i_leak_factor = 0; bus.i_ref_period = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_vmem", bus.o_vmem, 64'd0);
        chk("rst_refcnt", 64'(bus.o_refcnt), 64'd0);
        chk("rst_spike", 64'(bus.o_spike), 64'd0);
        rst = 1'b0;

        tq.delete();
        run_neuron("leak_only", qf(-60.0), 8'd0, tq, -70, -50, -65, qf(0.25), 8'd4,
                   -1, 0, 0, qf(-62.5), 8'd0, 1'b0);

        @(negedge clk);
        bus.i_start = 1; bus.i_no_input = 0; bus.i_vmem = qi(5); bus.i_refcnt = 0;
        @(negedge clk);
        bus.i_start = 0; bus.i_ipsc_valid = 1; bus.i_ipsc = qi(1); bus.i_ipsc_last = 0;
        @(negedge clk);
        bus.i_ipsc_valid = 0; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        chk("midrst_done", 64'(bus.o_done), 64'd0);
        chk("midrst_vmem", bus.o_vmem, 64'd0);
        chk("midrst_refcnt", 64'(bus.o_refcnt), 64'd0);
        chk("midrst_spike", 64'(bus.o_spike), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        tq.delete(); tq.push_back(qf(5.5)); tq.push_back(qf(3.0)); tq.push_back(qf(2.25));
        run_neuron("accumulate", qf(-70.0), 8'd0, tq, -70, -50, -65, qf(0.25), 8'd4,
                   1, 0, 0, qf(-59.25), 8'd0, 1'b0);

        tq.delete(); tq.push_back(qf(12.0)); tq.push_back(qf(8.0));
        run_neuron("spike_edge", qf(-70.0), 8'd0, tq, -70, -50, -65, qf(0.25), 8'd4,
                   -1, 0, 0, qi(-65), 8'd4, 1'b1);

        tq.delete(); tq.push_back(qf(100.0));
        run_neuron("refractory3", qf(-70.0), 8'd3, tq, -70, -50, -65, qf(0.25), 8'd4,
                   -1, 0, 0, qi(-65), 8'd2, 1'b0);

        tq.delete();
        run_neuron("refractory1", qf(-70.0), 8'd1, tq, -70, -50, -65, qf(0.25), 8'd4,
                   -1, 0, 0, qi(-65), 8'd0, 1'b0);

        tq.delete(); tq.push_back(64'sh7FFF_FFFF_FFFF_FFFF); tq.push_back(64'sh7FFF_FFFF_FFFF_FFFF);
        run_neuron("acc_sat_max", qi(-1), 8'd0, tq, -1, 32'sh7FFF_FFFF, -65, qf(0.0), 8'd4,
                   -1, 0, 0, 64'sh7FFF_FFFE_FFFF_FFFF, 8'd0, 1'b0);

        tq.delete(); tq.push_back(qf(-1.0));
        run_neuron("vnew_sat_min", 64'sh8000_0000_0000_0000, 8'd0, tq, 32'sh8000_0000,
                   -50, -65, qf(0.0), 8'd4, -1, 0, 0, 64'sh8000_0000_0000_0000, 8'd0, 1'b0);

        tq.delete(); tq.push_back(qi(100));
        run_neuron("vnew_sat_max", qi(32'sh7FFF_FFF0), 8'd0, tq, 32'sh7FFF_FFF0,
                   32'sh7FFF_FFFF, -65, qf(0.0), 8'd4, -1, 0, 0, qi(-65), 8'd4, 1'b1);

        idle_junk(3);
        tq.delete(); tq.push_back(qf(1.0)); tq.push_back(qf(2.0));
        run_neuron("protocol", qf(-60.0), 8'd0, tq, -70, -50, -65, qf(0.5), 8'd4,
                   0, 0, 1, qi(-62), 8'd0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            vm = {32'(int'($urandom_range(0, 200)) - 100), 32'($urandom())};
            rc = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            vrest = 32'(int'($urandom_range(0, 20)) - 80);
            vth = 32'(int'($urandom_range(0, 20)) - 60);
            vreset = 32'(int'($urandom_range(0, 15)) - 75);
            lf = {32'd0, 32'($urandom())};
            rp = 8'($urandom_range(1, 10));
            n = $urandom_range(0, 4);
            tq.delete();
            for (int j = 0; j < n; j++)
                tq.push_back({32'(int'($urandom_range(0, 32)) - 16), 32'($urandom())});
            model(vm, rc, tq, vrest, vth, vreset, lf, rp, ev, er, es);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_neuron($sformatf("rand%0d", k), vm, rc, tq, vrest, vth, vreset, lf, rp,
                       -1, 1, 0, ev, er, es);
        end

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
